bcd_counter_mux7seg: RTL and testbench

Parametrised N-digit BCD up/down counter with an integrated multiplexed 7-segment scan driver. It is the general-purpose successor to the cascaded per-digit decade counters and decade ring scanner in the front-panel display path. It adds parallel load, wrap or saturate mode, borrow/carry strobes, leading-zero blanking and selectable output polarity. It sits between button/timebase logic and the board's common-segment display pins.

---
 rtl/bcd_counter_mux7seg.sv | 198 +++++++++++++++++++
 tb/tb_bcd_counter_mux7seg.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_mux7seg.sv
// N-digit BCD up/down counter with parallel load, carry/borrow strobes and a
// time-multiplexed 7-segment scan driver with leading-zero blanking.
module bcd_counter_mux7seg #(
    parameter int unsigned DIGITS         = 3,
    parameter int unsigned SCAN_DIV       = 65536,
    parameter bit          WRAP           = 1'b1,
    parameter bit          BLANK_LZ       = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter bit          DIG_ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  up_en,
    input  logic                  dn_en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  carry,
    output logic                  borrow,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     dig
);

    localparam int unsigned BW     = 4 * DIGITS;
    localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [BW-1:0]     ALL_NINE = {DIGITS{4'h9}};
    localparam logic [6:0]        SEG_POL  = {7{SEG_ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] DIG_POL  = {DIGITS{DIG_ACTIVE_LOW}};
    localparam logic [6:0]        SEG_ZERO = 7'b0111111;
    localparam logic [DIGITS-1:0] DIG_ONE  = DIGITS'(1);

    // Active-high GFEDCBA pattern for one BCD digit.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b0111111;
            4'd1:    p = 7'b0000110;
            4'd2:    p = 7'b1011011;
            4'd3:    p = 7'b1001111;
            4'd4:    p = 7'b1100110;
            4'd5:    p = 7'b1101101;
            4'd6:    p = 7'b1111101;
            4'd7:    p = 7'b0000111;
            4'd8:    p = 7'b1111111;
            4'd9:    p = 7'b1101111;
            default: p = 7'b0000000;
        endcase
        return p;
    endfunction

    logic [BW-1:0] inc_val;
    logic [BW-1:0] dec_val;
    logic [BW-1:0] clamp_val;
    logic [BW-1:0] bcd_next;
    logic          inc_rip;
    logic          dec_rip;
    logic          all_nine;
    logic          all_zero;
    logic          carry_next;
    logic          borrow_next;

    // Ripple increment/decrement, limit detection and load clamping.
    always_comb begin
        inc_val   = bcd;
        dec_val   = bcd;
        clamp_val = '0;
        inc_rip   = 1'b1;
        dec_rip   = 1'b1;
        all_nine  = 1'b1;
        all_zero  = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd[4*i +: 4] != 4'd9) all_nine = 1'b0;
            if (bcd[4*i +: 4] != 4'd0) all_zero = 1'b0;
            if (inc_rip) begin
                if (bcd[4*i +: 4] >= 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
                    inc_rip = 1'b0;
                end
            end
            if (dec_rip) begin
                if (bcd[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = bcd[4*i +: 4] - 4'd1;
                    dec_rip = 1'b0;
                end
            end
            clamp_val[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
        end
    end

    // Priority: load, then conflicting strobes hold, then up, then down.
    always_comb begin
        bcd_next    = bcd;
        carry_next  = 1'b0;
        borrow_next = 1'b0;
        if (load) begin
            bcd_next = clamp_val;
        end else if (up_en && dn_en) begin
            bcd_next = bcd;
        end else if (up_en) begin
            if (all_nine) begin
                carry_next = 1'b1;
                bcd_next   = WRAP ? '0 : bcd;
            end else begin
                bcd_next = inc_val;
            end
        end else if (dn_en) begin
            if (all_zero) begin
                borrow_next = 1'b1;
                bcd_next    = WRAP ? ALL_NINE : bcd;
            end else begin
                bcd_next = dec_val;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd    <= '0;
            carry  <= 1'b0;
            borrow <= 1'b0;
        end else begin
            bcd    <= bcd_next;
            carry  <= carry_next;
            borrow <= borrow_next;
        end
    end

    logic [SCAN_W-1:0] scan_cnt;
    logic [IDX_W-1:0]  scan_idx;
    logic              scan_tc;

    assign scan_tc = (scan_cnt == SCAN_W'(SCAN_DIV - 1));

    // Free-running dwell counter; the digit index advances at its terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else begin
            if (scan_tc) begin
                scan_cnt <= '0;
                if (DIGITS > 1) begin
                    scan_idx <= (scan_idx == IDX_W'(DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
                end
            end else begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
            end
        end
    end

    logic [DIGITS-1:0] zero_from;
    logic [3:0]        cur_nib;
    logic              cur_zero_from;
    logic              cur_blank;
    logic [6:0]        seg_pat;
    logic [DIGITS-1:0] dig_oh;

    // zero_from[i] is set when digits i..DIGITS-1 are all zero.
    always_comb begin
        zero_from              = '0;
        zero_from[DIGITS-1]    = (bcd[BW-1 -: 4] == 4'd0);
        for (int i = int'(DIGITS) - 2; i >= 0; i--) begin
            zero_from[i] = zero_from[i+1] && (bcd[4*i +: 4] == 4'd0);
        end
    end

    always_comb begin
        cur_nib       = 4'd0;
        cur_zero_from = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (scan_idx == IDX_W'(i)) begin
                cur_nib       = bcd[4*i +: 4];
                cur_zero_from = zero_from[i];
            end
        end
        cur_blank = BLANK_LZ && (scan_idx != '0) && cur_zero_from;
        seg_pat   = cur_blank ? 7'b0000000 : seg_decode(cur_nib);
        dig_oh    = DIG_ONE << scan_idx;
    end

    // seg and dig share one register stage so they always describe the same slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= SEG_ZERO ^ SEG_POL;
            dig <= DIG_ONE ^ DIG_POL;
        end else begin
            seg <= seg_pat ^ SEG_POL;
            dig <= dig_oh ^ DIG_POL;
        end
    end

endmodule

// File: tb/tb_bcd_counter_mux7seg.sv
// Bench for bcd_counter_mux7seg: two configurations (wrap/active-high and
// saturate/active-low) checked against a decimal-arithmetic model each cycle.
module tb_bcd_counter_mux7seg;

    localparam int D  = 3;
    localparam int SD = 4;
    localparam int MAXV = 999;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        up_en = 1'b0;
    logic        dn_en = 1'b0;
    logic        load = 1'b0;
    logic [11:0] load_val = '0;

    logic [11:0] bcd0, bcd1;
    logic        carry0, carry1, borrow0, borrow1;
    logic [6:0]  seg0, seg1;
    logic [2:0]  dig0, dig1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    bcd_counter_mux7seg #(
        .DIGITS(D), .SCAN_DIV(SD), .WRAP(1'b1), .BLANK_LZ(1'b1),
        .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
    ) dut0 (
        .clk(clk), .rst(rst), .up_en(up_en), .dn_en(dn_en), .load(load),
        .load_val(load_val), .bcd(bcd0), .carry(carry0), .borrow(borrow0),
        .seg(seg0), .dig(dig0)
    );

    bcd_counter_mux7seg #(
        .DIGITS(D), .SCAN_DIV(SD), .WRAP(1'b0), .BLANK_LZ(1'b1),
        .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
    ) dut1 (
        .clk(clk), .rst(rst), .up_en(up_en), .dn_en(dn_en), .load(load),
        .load_val(load_val), .bcd(bcd1), .carry(carry1), .borrow(borrow1),
        .seg(seg1), .dig(dig1)
    );

    logic [6:0] pat [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                             7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

    // Model state: counts as plain integers, display as (slot, value shown).
    int m_val [2] = '{0, 0};
    int m_c   [2] = '{0, 0};
    int m_b   [2] = '{0, 0};
    int d_val [2] = '{0, 0};
    int d_idx = 0;
    int edges = 0;

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r = '0;
        for (int i = 0; i < D; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    function automatic int clamp_load(input logic [11:0] lv);
        int v = 0;
        for (int i = 0; i < D; i++) begin
            int n = int'(lv[4*i +: 4]);
            v += ((n > 9) ? 9 : n) * pow10(i);
        end
        return v;
    endfunction

    function automatic logic [6:0] exp_seg(input int k);
        int v = d_val[k];
        logic [6:0] p;
        if (d_idx > 0 && v < pow10(d_idx)) p = 7'b0000000;
        else p = pat[(v / pow10(d_idx)) % 10];
        return (k == 1) ? ~p : p;
    endfunction

    function automatic logic [2:0] exp_dig(input int k);
        logic [2:0] oh = 3'(1 << d_idx);
        return (k == 1) ? ~oh : oh;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            edges = 0;
            d_idx = 0;
            for (int k = 0; k < 2; k++) begin
                m_val[k] = 0; m_c[k] = 0; m_b[k] = 0; d_val[k] = 0;
            end
        end else begin
            d_idx = (edges / SD) % D;
            edges++;
            for (int k = 0; k < 2; k++) begin
                d_val[k] = m_val[k];
                m_c[k] = 0;
                m_b[k] = 0;
                if (load) begin
                    m_val[k] = clamp_load(load_val);
                end else if (up_en && dn_en) begin
                    m_val[k] = m_val[k];
                end else if (up_en) begin
                    if (m_val[k] == MAXV) begin
                        m_c[k] = 1;
                        m_val[k] = (k == 0) ? 0 : MAXV;
                    end else m_val[k] = m_val[k] + 1;
                end else if (dn_en) begin
                    if (m_val[k] == 0) begin
                        m_b[k] = 1;
                        m_val[k] = (k == 0) ? MAXV : 0;
                    end else m_val[k] = m_val[k] - 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        check("m0.bcd", 32'(bcd0), 32'(to_bcd(m_val[0])));
        check("m0.carry", 32'(carry0), 32'(m_c[0]));
        check("m0.borrow", 32'(borrow0), 32'(m_b[0]));
        check("m0.seg", 32'(seg0), 32'(exp_seg(0)));
        check("m0.dig", 32'(dig0), 32'(exp_dig(0)));
        check("m1.bcd", 32'(bcd1), 32'(to_bcd(m_val[1])));
        check("m1.carry", 32'(carry1), 32'(m_c[1]));
        check("m1.borrow", 32'(borrow1), 32'(m_b[1]));
        check("m1.seg", 32'(seg1), 32'(exp_seg(1)));
        check("m1.dig", 32'(dig1), 32'(exp_dig(1)));
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_load(input logic [11:0] v);
        load = 1'b1; load_val = v;
        tick();
        load = 1'b0;
    endtask

    task automatic wait_dig0(input logic [2:0] t);
        bit hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            tick();
            if (dig0 === t) hit = 1'b1;
        end
        check("wait_dig0", 32'(hit), 32'd1);
    endtask

    initial begin
        tick(); tick();
        check("rst.bcd0", 32'(bcd0), 32'h000);
        check("rst.dig0", 32'(dig0), 32'b001);
        check("rst.seg0", 32'(seg0), 32'b0111111);
        check("rst.seg1", 32'(seg1), 32'b1000000);
        check("rst.dig1", 32'(dig1), 32'b110);
        rst = 1'b0;

        // Idle scan: each slot held SD clocks, display one clock behind index.
        for (int n = 1; n <= 13; n++) begin
            tick();
            if (n == 1 || n == 4 || n == 13) check("scan.d0", 32'(dig0), 32'b001);
            if (n == 5 || n == 8) check("scan.d1", 32'(dig0), 32'b010);
            if (n == 9 || n == 12) check("scan.d2", 32'(dig0), 32'b100);
        end

        do_load(12'h998);
        check("ld998", 32'(bcd0), 32'h998);
        up_en = 1'b1;
        tick();
        check("up1.bcd0", 32'(bcd0), 32'h999);
        check("up1.carry0", 32'(carry0), 32'd0);
        tick();
        check("up2.bcd0", 32'(bcd0), 32'h000);
        check("up2.carry0", 32'(carry0), 32'd1);
        check("up2.bcd1", 32'(bcd1), 32'h999);
        check("up2.carry1", 32'(carry1), 32'd1);
        up_en = 1'b0;
        tick();
        check("up3.carry0", 32'(carry0), 32'd0);

        do_load(12'h000);
        dn_en = 1'b1;
        tick();
        dn_en = 1'b0;
        check("dn.bcd0", 32'(bcd0), 32'h999);
        check("dn.borrow0", 32'(borrow0), 32'd1);
        check("dn.bcd1", 32'(bcd1), 32'h000);
        check("dn.borrow1", 32'(borrow1), 32'd1);

        do_load(12'h045);
        up_en = 1'b1; dn_en = 1'b1;
        tick();
        dn_en = 1'b0;
        check("both.bcd0", 32'(bcd0), 32'h045);
        check("both.carry0", 32'(carry0), 32'd0);
        do_load(12'hA3F);
        up_en = 1'b0;
        check("ldclamp", 32'(bcd0), 32'h939);

        do_load(12'h007);
        wait_dig0(3'b100); check("lz7.d2", 32'(seg0), 32'b0000000);
        wait_dig0(3'b001); check("lz7.d0", 32'(seg0), 32'b0000111);
        wait_dig0(3'b010); check("lz7.d1", 32'(seg0), 32'b0000000);
        do_load(12'h100);
        wait_dig0(3'b010); check("lz100.d1", 32'(seg0), 32'b0111111);
        wait_dig0(3'b100); check("lz100.d2", 32'(seg0), 32'b0000110);
        do_load(12'h000);
        wait_dig0(3'b100); check("lz0.d2", 32'(seg0), 32'b0000000);
        wait_dig0(3'b001); check("lz0.d0", 32'(seg0), 32'b0111111);

        // Asynchronous reset in the middle of a cycle while slot 2 is shown.
        do_load(12'h512);
        wait_dig0(3'b100);
        #2 rst = 1'b1;
        #1;
        check("arst.seg1", 32'(seg1), 32'b1000000);
        check("arst.dig1", 32'(dig1), 32'b110);
        check("arst.bcd1", 32'(bcd1), 32'h000);
        check("arst.dig0", 32'(dig0), 32'b001);
        tick(); tick();
        rst = 1'b0;
        up_en = 1'b1;
        tick();
        up_en = 1'b0;
        check("resume.bcd0", 32'(bcd0), 32'h001);

        // Randomised traffic, including occasional short async reset pulses.
        for (int n = 0; n < 2000; n++) begin
            int r = int'($urandom_range(0, 999));
            load  = (r < 60);
            up_en = ($urandom_range(0, 2) != 0);
            dn_en = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) load_val = ($urandom_range(0, 1) == 0) ? 12'h000 : 12'h999;
            else load_val = 12'($urandom_range(0, 4095));
            if (r >= 995) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
            tick();
        end
        load = 1'b0; up_en = 1'b0; dn_en = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
